// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces the two coin-slot sensors, turns each
// clean rising insertion into a 2-bit coin code, queues the codes and hands them
// downstream as single-cycle pulses separated by a minimum idle gap.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned GAP_CYCLES      = 1,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin5_raw,
    input  logic             coin10_raw,
    input  logic             coin_ready,
    output logic [1:0]       coin,
    output logic             reject,
    output logic             jam,
    output logic [CNT_W-1:0] coin_cnt
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DB_LAST = DEBOUNCE_CYCLES - 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    // Channel index 0 is the 5-unit slot, index 1 the 10-unit slot.
    logic [1:0]       s1_q, s1_d;
    logic [1:0]       s2_q, s2_d;
    logic [1:0]       db_q, db_d;
    logic [DB_W-1:0]  db_cnt_q [2];
    logic [DB_W-1:0]  db_cnt_d [2];

    logic [1:0]       mem_q [FIFO_DEPTH];
    logic [1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [GAP_W-1:0] gap_q, gap_d;
    logic [1:0]       coin_q, coin_d;
    logic             reject_q, reject_d;
    logic             jam_q, jam_d;
    logic [CNT_W-1:0] coin_cnt_q, coin_cnt_d;

    logic [1:0]       rise_c;
    logic             single_c;
    logic             full_c;
    logic             push_c;
    logic             pop_c;
    logic [1:0]       push_code_c;

    assign coin     = coin_q;
    assign reject   = reject_q;
    assign jam      = jam_q;
    assign coin_cnt = coin_cnt_q;

    // Two-flop synchroniser per raw sensor line.
    always_comb begin
        s1_d = {coin10_raw, coin5_raw};
        s2_d = s1_q;
    end

    // Debounce: accept a level only after it differs from db for DEBOUNCE_CYCLES edges.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        rise_c   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DB_LAST)) begin
                    db_d[i]     = s2_q[i];
                    db_cnt_d[i] = '0;
                    rise_c[i]   = s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Event classification: simultaneous rises jam, a lone rise is queued or rejected.
    always_comb begin
        single_c    = rise_c[0] ^ rise_c[1];
        full_c      = (occ_q == OCC_W'(FIFO_DEPTH));
        push_code_c = rise_c[1] ? COIN_10 : COIN_5;
        jam_d       = (rise_c == 2'b11);
        reject_d    = single_c && full_c;
        push_c      = single_c && !full_c;
    end

    // Emit: pop the head when allowed, otherwise drive idle and run down the gap.
    always_comb begin
        pop_c      = (occ_q != '0) && coin_ready && (gap_q == '0);
        coin_d     = COIN_NONE;
        gap_d      = gap_q;
        coin_cnt_d = coin_cnt_q;
        if (pop_c) begin
            coin_d = mem_q[rd_ptr_q];
            gap_d  = GAP_W'(GAP_CYCLES);
            if (coin_cnt_q != {CNT_W{1'b1}}) begin
                coin_cnt_d = coin_cnt_q + CNT_W'(1);
            end
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end
    end

    // FIFO storage, wrapping pointers and occupancy count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = push_code_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_c, pop_c})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State register with synchronous active-low reset; debounced levels reset high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q       <= 2'b00;
            s2_q       <= 2'b00;
            db_q       <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int j = 0; j < int'(FIFO_DEPTH); j++) begin
                mem_q[j] <= COIN_NONE;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            gap_q      <= '0;
            coin_q     <= COIN_NONE;
            reject_q   <= 1'b0;
            jam_q      <= 1'b0;
            coin_cnt_q <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            gap_q      <= gap_d;
            coin_q     <= coin_d;
            reject_q   <= reject_d;
            jam_q      <= jam_d;
            coin_cnt_q <= coin_cnt_d;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: scoreboard bench; tests push the coin codes they expect and a
// negedge monitor pops and compares every coin pulse the DUT emits.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin5_raw;
    logic       coin10_raw;
    logic       coin_ready;
    logic [1:0] coin;
    logic       reject;
    logic       jam;
    logic [7:0] coin_cnt;

    logic [1:0] exp_q [$];
    logic [1:0] prev_coin = 2'b00;
    int         n_cmp  = 0;
    int         n_err  = 0;
    int         n_seen = 0;
    int         n_rej  = 0;
    int         n_jam  = 0;

    coin_acceptor dut (
        .clk        (clk),
        .rst        (rst),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .coin_ready (coin_ready),
        .coin       (coin),
        .reject     (reject),
        .jam        (jam),
        .coin_cnt   (coin_cnt)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One insertion on a slot: high for hi cycles, then low for lo cycles.
    task automatic insert(input bit ten, input int hi, input int lo);
        if (ten) coin10_raw = 1'b1; else coin5_raw = 1'b1;
        tick(hi);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        tick(lo);
    endtask

    // Monitor: every coin pulse must match the scoreboard head and follow an idle cycle.
    always @(negedge clk) begin
        if (coin != 2'b00) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_coin", 32'(coin), 32'd0);
            end else begin
                check_eq("coin_code", 32'(coin), 32'(exp_q.pop_front()));
            end
            if (prev_coin != 2'b00) begin
                check_eq("coin_gap", 32'(prev_coin), 32'd0);
            end
        end
        if (reject) n_rej++;
        if (jam)    n_jam++;
        prev_coin = coin;
    end

    initial begin
        int base_jam;
        int base_rej;
        int base_seen;

        rst        = 1'b0;
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        coin_ready = 1'b1;

        // Reset with raw lines low.
        tick(3);
        check_eq("rst_coin",     32'(coin),     32'd0);
        check_eq("rst_reject",   32'(reject),   32'd0);
        check_eq("rst_jam",      32'(jam),      32'd0);
        check_eq("rst_coin_cnt", 32'(coin_cnt), 32'd0);
        rst = 1'b1;
        tick(8);

        // Single 10-unit coin: pulse appears 6 cycles after the first sampling edge.
        exp_q.push_back(2'b10);
        coin10_raw = 1'b1;
        tick(6);
        check_eq("lat_before", 32'(coin), 32'd0);
        tick(1);
        check_eq("lat_at",     32'(coin), 32'd2);
        tick(1);
        check_eq("lat_after",  32'(coin), 32'd0);
        tick(2);
        coin10_raw = 1'b0;
        tick(10);
        check_eq("c10_cnt", 32'(coin_cnt), 32'd1);

        // Short pulse and fast toggling are both filtered out.
        base_seen = n_seen;
        insert(1'b0, 3, 8);
        for (int k = 0; k < 4; k++) insert(1'b0, 1, 1);
        tick(10);
        check_eq("glitch_cnt",  32'(coin_cnt), 32'd1);
        check_eq("glitch_seen", 32'(n_seen - base_seen), 32'd0);

        // Both slots rise together: one jam pulse, nothing queued.
        base_jam  = n_jam;
        base_seen = n_seen;
        coin5_raw  = 1'b1;
        coin10_raw = 1'b1;
        tick(10);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        tick(10);
        check_eq("jam_pulses", 32'(n_jam - base_jam), 32'd1);
        check_eq("jam_cnt",    32'(coin_cnt), 32'd1);
        check_eq("jam_seen",   32'(n_seen - base_seen), 32'd0);

        // Fresh reset, then overflow a held queue: fifth insertion is rejected.
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(8);
        check_eq("rst2_cnt", 32'(coin_cnt), 32'd0);
        coin_ready = 1'b0;
        base_rej   = n_rej;
        for (int k = 0; k < 5; k++) insert(1'b0, 6, 6);
        tick(4);
        check_eq("full_reject", 32'(n_rej - base_rej), 32'd1);
        check_eq("held_cnt",    32'(coin_cnt), 32'd0);
        for (int k = 0; k < 4; k++) exp_q.push_back(2'b01);
        coin_ready = 1'b1;
        tick(20);
        check_eq("drain_cnt",   32'(coin_cnt), 32'd4);
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

        // Queued coins are discarded by a mid-operation reset.
        coin_ready = 1'b0;
        for (int k = 0; k < 3; k++) insert(1'b1, 6, 6);
        base_seen = n_seen;
        rst = 1'b0;
        tick(1);
        check_eq("midrst_coin", 32'(coin),     32'd0);
        check_eq("midrst_cnt",  32'(coin_cnt), 32'd0);
        rst = 1'b1;
        coin_ready = 1'b1;
        tick(20);
        check_eq("flush_seen", 32'(n_seen - base_seen), 32'd0);
        check_eq("flush_cnt",  32'(coin_cnt), 32'd0);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
